spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on spi_clk, spi_cs_n and spi_mosi (minimum 2).
REQ-002 clk  input  1  system clock; the only clock in the block; all logic on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 CPOL  input  1  SPI clock idle level.
REQ-005 CPHA  input  1  0: sample on leading edge; 1: sample on trailing edge.
REQ-006 spi_clk  input  1  serial clock from the master; asynchronous to clk.
REQ-007 spi_cs_n  input  1  chip select, active low.
REQ-008 spi_mosi  input  1  serial data from the master.
REQ-009 spi_miso  output  1  serial data to the master.
REQ-010 tx_data  input  8  byte to return to the master.
REQ-011 tx_valid  input  1  tx_data offered.
REQ-012 tx_ready  output  1  holding register empty; the byte is accepted when tx_valid and tx_ready are both high.
REQ-013 rx_data  output  8  last complete received byte.
REQ-014 rx_valid  output  1  one-cycle strobe marking new rx_data.
REQ-015 tx_underrun  output  1  one-cycle strobe: shifter loaded while the holding register was empty.
REQ-016 busy  output  1  high while synchronized spi_cs_n is low.

Function
REQ-017 spi_clk, spi_cs_n and spi_mosi SHALL each pass through SYNC_STAGES flops; edges SHALL be detected only on the synchronized spi_clk and spi_cs_n.
REQ-018 CPOL and CPHA SHALL be latched on the synchronized falling edge of spi_cs_n; changes during an active select SHALL be ignored.
REQ-019 Edge definitions: leading edge = synchronized spi_clk leaving CPOL; trailing edge = returning to CPOL; sample edge = leading when CPHA=0, trailing when CPHA=1; drive edge = the other one.
REQ-020 Bit order SHALL be MSB first in both directions; the word length is fixed at 8 bits.
REQ-021 States: IDLE (deselected) and ACTIVE; IDLE->ACTIVE on synchronized CS fall; ACTIVE->IDLE on synchronized CS rise.
REQ-022 On each sample edge in ACTIVE, synchronized spi_mosi SHALL shift into the rx shifter and the 3-bit bit counter SHALL increment, wrapping 7->0.
REQ-023 On the 8th sample edge, rx_data SHALL update and rx_valid SHALL pulse high for exactly one clk, in the cycle after edge detection.
REQ-024 Tx shifter load for CPHA=0: at the CS fall, and at the drive edge that follows the 8th sample edge.
REQ-025 Tx shifter load for CPHA=1: at the first drive edge of each byte.
REQ-026 On load, the tx shifter SHALL take the holding register if it is full and mark it empty; otherwise it SHALL load 8'h00 and pulse tx_underrun.
REQ-027 spi_miso SHALL equal tx shifter bit 7; the shifter SHALL shift left on each non-load drive edge in ACTIVE; spi_miso SHALL be 0 in IDLE.
REQ-028 tx_ready SHALL be high exactly when the holding register is empty.
REQ-029 tx_valid while tx_ready is low SHALL be ignored, and the holding register SHALL keep its contents.
REQ-030 A tx_valid handshake and a shifter load in the same cycle: the load SHALL take the old holding state, and the new byte SHALL occupy the holding register afterwards.
REQ-031 CS rise mid-byte SHALL discard the partial byte: no rx_valid, bit counter cleared, rx_data unchanged, holding register unchanged.
REQ-032 Correct operation SHALL be guaranteed for spi_clk half-periods of at least SYNC_STAGES+2 clk cycles.
REQ-033 busy SHALL follow synchronized CS with no added latency beyond the synchronizer.

Reset
REQ-034 While rst_n is low, regardless of clk, outputs SHALL be: spi_miso=0, tx_ready=1, rx_data=8'h00, rx_valid=0, tx_underrun=0, busy=0.
REQ-035 While rst_n is low, all internal state SHALL be: synchronizers at idle (spi_cs_n=1, spi_clk=0), shifters and bit counter at 0, state IDLE, holding register empty.
REQ-036 Reset asserted mid-byte SHALL abort the transfer; after release the block SHALL wait for a fresh CS fall.

Verification
REQ-037 Mode 0 (CPOL=0, CPHA=0), holding preloaded with 8'hA5, master sends 8'hAF -> one rx_valid with rx_data=8'hAF; master receives 8'hA5; tx_ready returns to 1.
REQ-038 Mode 2 (CPOL=1, CPHA=0), master clk divide 4, holding 8'h3C, master sends 8'h55 -> rx_data=8'h55; master receives 8'h3C.
REQ-039 Mode 3, one CS, master sends 8'h12 then 8'h34, only 8'hC3 preloaded -> two rx_valid pulses (8'h12, 8'h34); master receives 8'hC3, 8'h00; exactly one tx_underrun pulse.
REQ-040 CS raised after 5 bits, then a full byte 8'h81 sent -> no rx_valid for the partial byte; a single rx_valid with 8'h81.
REQ-041 rst_n pulled low after 3 bits of a byte -> all outputs at reset values immediately; the next full transfer of 8'hF0 after release is received correctly.
REQ-042 tx_valid with 8'h77 while holding full with 8'h11 -> 8'h77 ignored; master receives 8'h11.

Source files
------------

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus the byte-level tx/rx handshake of the SPI slave.
// Signals:
//   CPOL, CPHA           mode select, latched by the slave at each select
//   spi_clk, spi_cs_n,   serial clock, chip select (active low) and data from master
//   spi_mosi
//   spi_miso             serial data to master
//   tx_data, tx_valid,   byte offered for transmission / holding register empty
//   tx_ready
//   rx_data, rx_valid    last received byte / one-cycle new-byte strobe
//   tx_underrun          one-cycle strobe: shifter loaded from an empty holding register
//   busy                 synchronized chip select is active
interface spi_slave_if;
    logic       CPOL;
    logic       CPHA;
    logic       spi_clk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;
    modport slave (
        input  CPOL, CPHA, spi_clk, spi_cs_n, spi_mosi, tx_data, tx_valid,
        output spi_miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );
    modport master (
        output CPOL, CPHA, spi_clk, spi_cs_n, spi_mosi, tx_data, tx_valid,
        input  spi_miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI slave, 8-bit MSB-first, all four SPI modes.
// Ports:
//   clk     system clock, the only clock; spi_clk is sampled as data
//   rst_n   asynchronous active-low reset
//   bus     spi_slave_if.slave (SPI pins, tx holding-register handshake, rx strobe)
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input logic        clk,
    input logic        rst_n,
    spi_slave_if.slave bus
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic [0:0]             state_q, state_d;
    logic                   cpol_q, cpol_d, cpha_q, cpha_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [6:0]             rx_sh_q, rx_sh_d;
    logic [7:0]             rx_data_q, rx_data_d, tx_sh_q, tx_sh_d, hold_q, hold_d;
    logic                   hold_full_q, hold_full_d, rx_valid_q, rx_valid_d, urun_q, urun_d;
    logic                   sclk_s, cs_s, mosi_s, cs_fall, cs_rise, active;
    logic                   leading, trailing, sample, drive, load;
    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    assign cs_fall = cs_prev_q & ~cs_s;
    assign cs_rise = ~cs_prev_q & cs_s;
    assign active  = (state_q == ACTIVE) & ~cs_rise;
    // leading edge leaves the idle level, trailing edge returns to it
    assign leading  = (sclk_s != sclk_prev_q) & (sclk_prev_q == cpol_q);
    assign trailing = (sclk_s != sclk_prev_q) & (sclk_s == cpol_q);
    assign sample   = active & (cpha_q ? trailing : leading);
    assign drive    = active & (cpha_q ? leading : trailing);
    // a drive edge with the bit counter at 0 starts a byte: for CPHA=0 it is the
    // edge after the 8th sample, for CPHA=1 the first edge of the byte
    assign load = ((state_q == IDLE) & cs_fall & ~bus.CPHA) | (drive & (cnt_q == 3'd0));
    always_comb begin
        state_d     = state_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        cnt_d       = cnt_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_sh_d     = tx_sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        urun_d      = 1'b0;
        if (state_q == IDLE && cs_fall) begin
            state_d = ACTIVE;
            cpol_d  = bus.CPOL;
            cpha_d  = bus.CPHA;
            cnt_d   = 3'd0;
            tx_sh_d = 8'h00;
        end
        if (state_q == ACTIVE && cs_rise) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
        end
        if (sample) begin
            rx_sh_d = {rx_sh_q[5:0], mosi_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                rx_data_d  = {rx_sh_q, mosi_s};
                rx_valid_d = 1'b1;
            end
        end
        if (load) begin
            tx_sh_d     = hold_full_q ? hold_q : 8'h00;
            urun_d      = ~hold_full_q;
            hold_full_d = 1'b0;
        end else if (drive) begin
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
        end
        // a handshake in the load cycle refills the holding register after the load
        if (bus.tx_valid && !hold_full_q) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            state_q     <= IDLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            cnt_q       <= 3'd0;
            rx_sh_q     <= 7'd0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_sh_q     <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            urun_q      <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_clk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            state_q     <= state_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            cnt_q       <= cnt_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_sh_q     <= tx_sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            urun_q      <= urun_d;
        end
    end
    assign bus.spi_miso    = (state_q == ACTIVE) & tx_sh_q[7];
    assign bus.tx_ready    = ~hold_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = urun_q;
    assign bus.busy        = ~cs_s;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized SPI master driving spi_slave, checked against a byte-level model.
module tb_spi_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    spi_slave_if bus();
    spi_slave #(.SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] rx_q[$];
    int         urun_cnt = 0;
    int         rx_base, ur_base;
    logic       m_full;
    logic [7:0] m_hold, m_rx_data;
    logic [7:0] mo_q[$], mi_q[$], exp_mi_q[$];
    int         exp_urun;
    bit         cur_cpol, cur_cpha;
    int         half;
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) rx_q.push_back(bus.rx_data);
        if (bus.tx_underrun === 1'b1) urun_cnt++;
    end
    task automatic push_tx(input logic [7:0] b);
        bus.tx_data = b;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        if (!m_full) begin
            m_full = 1'b1;
            m_hold = b;
        end
    endtask
    // Each byte slot of a transfer consumes one holding-register load; CPHA=0
    // additionally loads at select and after every complete byte.
    task automatic model_loads(input int nbits);
        int n = cur_cpha ? (nbits + 7) / 8 : 1 + nbits / 8;
        exp_mi_q = {};
        exp_urun = 0;
        for (int k = 0; k < n; k++) begin
            if (m_full) begin
                exp_mi_q.push_back(m_hold);
                m_full = 1'b0;
            end else begin
                exp_mi_q.push_back(8'h00);
                exp_urun++;
            end
        end
    endtask
    task automatic spi_xfer(input int nbits, input bit raise_cs);
        logic [7:0] acc = 8'h00;
        logic [7:0] tmp;
        bus.CPOL = cur_cpol;
        bus.CPHA = cur_cpha;
        bus.spi_clk = cur_cpol;
        repeat (4) @(negedge clk);
        rx_base = rx_q.size();
        ur_base = urun_cnt;
        mi_q = {};
        bus.spi_cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            tmp = mo_q[i / 8];
            if (!cur_cpha) begin
                bus.spi_mosi = tmp[7 - (i % 8)];
                repeat (half) @(negedge clk);
                if (i == 0) begin
                    bus.CPOL = 1'($urandom);
                    bus.CPHA = 1'($urandom);
                end
                acc = {acc[6:0], bus.spi_miso};
                bus.spi_clk = ~cur_cpol;
                repeat (half) @(negedge clk);
                bus.spi_clk = cur_cpol;
            end else begin
                repeat (half) @(negedge clk);
                if (i == 0) begin
                    bus.CPOL = 1'($urandom);
                    bus.CPHA = 1'($urandom);
                end
                bus.spi_clk = ~cur_cpol;
                bus.spi_mosi = tmp[7 - (i % 8)];
                repeat (half) @(negedge clk);
                acc = {acc[6:0], bus.spi_miso};
                bus.spi_clk = cur_cpol;
            end
            if (i % 8 == 7) mi_q.push_back(acc);
        end
        repeat (half) @(negedge clk);
        if (raise_cs) begin
            bus.spi_cs_n = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (bus.spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", bus.spi_miso); end
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b exp 1", bus.tx_ready); end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", bus.rx_valid); end
        checks++; if (bus.tx_underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b exp 0", bus.tx_underrun); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", bus.busy); end
    endtask
    task automatic test_busy();
        bus.CPHA = 1'b1;
        bus.spi_cs_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_early got %b exp 0", bus.busy); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_rise got %b exp 1", bus.busy); end
        bus.spi_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_fall got %b exp 0", bus.busy); end
        repeat (4) @(negedge clk);
    endtask
    task automatic test_mode0();
        logic [7:0] got;
        cur_cpol = 1'b0; cur_cpha = 1'b0; half = 4 + int'($urandom_range(2));
        push_tx(8'hA5);
        mo_q = {8'hAF};
        model_loads(8);
        spi_xfer(8, 1'b1);
        checks++; if (rx_q.size() - rx_base !== 1) begin errors++; $display("FAIL m0_rx_count got %0d exp 1", rx_q.size() - rx_base); end
        got = (rx_q.size() > rx_base) ? rx_q[rx_base] : 8'hxx;
        checks++; if (got !== 8'hAF) begin errors++; $display("FAIL m0_rx_byte got %h exp af", got); end
        checks++; if (bus.rx_data !== 8'hAF) begin errors++; $display("FAIL m0_rx_data got %h exp af", bus.rx_data); end
        got = (mi_q.size() > 0) ? mi_q[0] : 8'hxx;
        checks++; if (got !== 8'hA5) begin errors++; $display("FAIL m0_miso got %h exp a5", got); end
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL m0_tx_ready got %b exp 1", bus.tx_ready); end
        checks++; if (urun_cnt - ur_base !== exp_urun) begin errors++; $display("FAIL m0_underrun got %0d exp %0d", urun_cnt - ur_base, exp_urun); end
        m_rx_data = 8'hAF;
    endtask
    task automatic test_mode2();
        logic [7:0] got;
        cur_cpol = 1'b1; cur_cpha = 1'b0; half = 4;
        push_tx(8'h3C);
        mo_q = {8'h55};
        model_loads(8);
        spi_xfer(8, 1'b1);
        checks++; if (rx_q.size() - rx_base !== 1) begin errors++; $display("FAIL m2_rx_count got %0d exp 1", rx_q.size() - rx_base); end
        checks++; if (bus.rx_data !== 8'h55) begin errors++; $display("FAIL m2_rx_data got %h exp 55", bus.rx_data); end
        got = (mi_q.size() > 0) ? mi_q[0] : 8'hxx;
        checks++; if (got !== 8'h3C) begin errors++; $display("FAIL m2_miso got %h exp 3c", got); end
        checks++; if (urun_cnt - ur_base !== exp_urun) begin errors++; $display("FAIL m2_underrun got %0d exp %0d", urun_cnt - ur_base, exp_urun); end
        m_rx_data = 8'h55;
    endtask
    task automatic test_mode3();
        logic [7:0] got;
        cur_cpol = 1'b1; cur_cpha = 1'b1; half = 4 + int'($urandom_range(2));
        push_tx(8'hC3);
        mo_q = {8'h12, 8'h34};
        model_loads(16);
        spi_xfer(16, 1'b1);
        checks++; if (rx_q.size() - rx_base !== 2) begin errors++; $display("FAIL m3_rx_count got %0d exp 2", rx_q.size() - rx_base); end
        got = (rx_q.size() > rx_base) ? rx_q[rx_base] : 8'hxx;
        checks++; if (got !== 8'h12) begin errors++; $display("FAIL m3_rx0 got %h exp 12", got); end
        got = (rx_q.size() > rx_base + 1) ? rx_q[rx_base + 1] : 8'hxx;
        checks++; if (got !== 8'h34) begin errors++; $display("FAIL m3_rx1 got %h exp 34", got); end
        got = (mi_q.size() > 0) ? mi_q[0] : 8'hxx;
        checks++; if (got !== 8'hC3) begin errors++; $display("FAIL m3_miso0 got %h exp c3", got); end
        got = (mi_q.size() > 1) ? mi_q[1] : 8'hxx;
        checks++; if (got !== 8'h00) begin errors++; $display("FAIL m3_miso1 got %h exp 00", got); end
        checks++; if (urun_cnt - ur_base !== 1) begin errors++; $display("FAIL m3_underrun got %0d exp 1", urun_cnt - ur_base); end
        m_rx_data = 8'h34;
    endtask
    task automatic test_abort();
        logic [7:0] got;
        cur_cpol = 1'($urandom); cur_cpha = 1'($urandom); half = 4 + int'($urandom_range(2));
        push_tx(8'($urandom));
        mo_q = {8'($urandom)};
        model_loads(5);
        spi_xfer(5, 1'b1);
        checks++; if (rx_q.size() - rx_base !== 0) begin errors++; $display("FAIL abort_rx_count got %0d exp 0", rx_q.size() - rx_base); end
        checks++; if (bus.rx_data !== m_rx_data) begin errors++; $display("FAIL abort_rx_data got %h exp %h", bus.rx_data, m_rx_data); end
        checks++; if (urun_cnt - ur_base !== exp_urun) begin errors++; $display("FAIL abort_underrun got %0d exp %0d", urun_cnt - ur_base, exp_urun); end
        push_tx(8'($urandom));
        mo_q = {8'h81};
        model_loads(8);
        spi_xfer(8, 1'b1);
        checks++; if (rx_q.size() - rx_base !== 1) begin errors++; $display("FAIL abort_next_count got %0d exp 1", rx_q.size() - rx_base); end
        checks++; if (bus.rx_data !== 8'h81) begin errors++; $display("FAIL abort_next_data got %h exp 81", bus.rx_data); end
        got = (mi_q.size() > 0) ? mi_q[0] : 8'hxx;
        checks++; if (got !== exp_mi_q[0]) begin errors++; $display("FAIL abort_next_miso got %h exp %h", got, exp_mi_q[0]); end
        m_rx_data = 8'h81;
    endtask
    task automatic test_reset_mid();
        logic [7:0] got;
        cur_cpol = 1'($urandom); cur_cpha = 1'($urandom); half = 4;
        push_tx(8'($urandom));
        mo_q = {8'($urandom)};
        spi_xfer(3, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.spi_miso !== 1'b0) begin errors++; $display("FAIL rmid_miso got %b exp 0", bus.spi_miso); end
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL rmid_tx_ready got %b exp 1", bus.tx_ready); end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL rmid_rx_data got %h exp 00", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL rmid_rx_valid got %b exp 0", bus.rx_valid); end
        checks++; if (bus.tx_underrun !== 1'b0) begin errors++; $display("FAIL rmid_underrun got %b exp 0", bus.tx_underrun); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", bus.busy); end
        bus.spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_full = 1'b0;
        m_rx_data = 8'h00;
        repeat (3) @(negedge clk);
        cur_cpol = 1'($urandom); cur_cpha = 1'($urandom); half = 4 + int'($urandom_range(2));
        push_tx(8'($urandom));
        mo_q = {8'hF0};
        model_loads(8);
        spi_xfer(8, 1'b1);
        checks++; if (rx_q.size() - rx_base !== 1) begin errors++; $display("FAIL rmid_next_count got %0d exp 1", rx_q.size() - rx_base); end
        checks++; if (bus.rx_data !== 8'hF0) begin errors++; $display("FAIL rmid_next_data got %h exp f0", bus.rx_data); end
        got = (mi_q.size() > 0) ? mi_q[0] : 8'hxx;
        checks++; if (got !== exp_mi_q[0]) begin errors++; $display("FAIL rmid_next_miso got %h exp %h", got, exp_mi_q[0]); end
        m_rx_data = 8'hF0;
    endtask
    task automatic test_hold_full();
        logic [7:0] got;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_full = 1'b0;
        m_rx_data = 8'h00;
        repeat (2) @(negedge clk);
        push_tx(8'h11);
        push_tx(8'h77);
        checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL hold_tx_ready got %b exp 0", bus.tx_ready); end
        cur_cpol = 1'($urandom); cur_cpha = 1'($urandom); half = 4 + int'($urandom_range(2));
        mo_q = {8'($urandom)};
        model_loads(8);
        spi_xfer(8, 1'b1);
        got = (mi_q.size() > 0) ? mi_q[0] : 8'hxx;
        checks++; if (got !== 8'h11) begin errors++; $display("FAIL hold_miso got %h exp 11", got); end
        checks++; if (bus.tx_ready !== !m_full) begin errors++; $display("FAIL hold_tx_ready_after got %b exp %b", bus.tx_ready, !m_full); end
        checks++; if (bus.rx_data !== mo_q[0]) begin errors++; $display("FAIL hold_rx_data got %h exp %h", bus.rx_data, mo_q[0]); end
        m_rx_data = mo_q[0];
    endtask
    task automatic test_random();
        logic [7:0] got;
        int nb;
        for (int it = 0; it < 8; it++) begin
            cur_cpol = 1'($urandom); cur_cpha = 1'($urandom); half = 4 + int'($urandom_range(2));
            for (int p = 0; p < int'($urandom_range(2)); p++) push_tx(8'($urandom));
            nb = 1 + int'($urandom_range(2));
            mo_q = {};
            for (int k = 0; k < nb; k++) mo_q.push_back(8'($urandom));
            model_loads(nb * 8);
            spi_xfer(nb * 8, 1'b1);
            checks++; if (rx_q.size() - rx_base !== nb) begin errors++; $display("FAIL rnd%0d_rx_count got %0d exp %0d", it, rx_q.size() - rx_base, nb); end
            for (int k = 0; k < nb; k++) begin
                got = (rx_q.size() > rx_base + k) ? rx_q[rx_base + k] : 8'hxx;
                checks++; if (got !== mo_q[k]) begin errors++; $display("FAIL rnd%0d_rx%0d got %h exp %h", it, k, got, mo_q[k]); end
                got = (mi_q.size() > k) ? mi_q[k] : 8'hxx;
                checks++; if (got !== exp_mi_q[k]) begin errors++; $display("FAIL rnd%0d_miso%0d got %h exp %h", it, k, got, exp_mi_q[k]); end
            end
            checks++; if (urun_cnt - ur_base !== exp_urun) begin errors++; $display("FAIL rnd%0d_underrun got %0d exp %0d", it, urun_cnt - ur_base, exp_urun); end
            checks++; if (bus.tx_ready !== !m_full) begin errors++; $display("FAIL rnd%0d_tx_ready got %b exp %b", it, bus.tx_ready, !m_full); end
            m_rx_data = mo_q[nb - 1];
            checks++; if (bus.rx_data !== m_rx_data) begin errors++; $display("FAIL rnd%0d_rx_data got %h exp %h", it, bus.rx_data, m_rx_data); end
        end
    endtask
    initial begin
        bus.CPOL = 1'b0;
        bus.CPHA = 1'b0;
        bus.spi_clk = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        bus.tx_data = 8'h00;
        bus.tx_valid = 1'b0;
        m_full = 1'b0;
        m_hold = 8'h00;
        m_rx_data = 8'h00;
        half = 4;
        test_reset();
        test_busy();
        test_mode0();
        test_mode2();
        test_mode3();
        test_abort();
        test_reset_mid();
        test_hold_full();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
